uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_txx` byte transmitter among `NUM_REQ` byte sources. It accepts bytes over a valid/ready handshake and pulses the transmitter's start strobe once per byte. It then waits for the transmitter's done pulse before issuing the next byte. Multi-byte messages are kept contiguous by a per-message grant lock, and a watchdog recovers from a stalled transmitter or an abandoned lock.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DONE_TIMEOUT`, 8192: cycle limit for WAIT_DONE and for the locked-owner wait. Must be > 10*clks_per_bit and ≤ 65535.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_req_valid` in NUM_REQ: requester k presents a byte.
- `i_req_data` in 8*NUM_REQ: byte of requester k on [8k+7:8k]. Stable while valid is high.
- `i_req_last` in NUM_REQ: the presented byte ends requester k's message.
- `o_req_ready` out NUM_REQ: one-hot, one-cycle accept pulse.
- `o_grant` out NUM_REQ: one-hot current owner. Zero when no owner.
- `o_busy` out 1: high in LAUNCH or WAIT_DONE.
- `o_timeout` out 1: one-cycle pulse on a watchdog expiry.
- `o_tx_data_avail` out 1: start strobe to `uart_txx`.
- `o_tx_databyte` out 8: byte to `uart_txx`.
- `i_tx_active` in 1: from `uart_txx` o_active.
- `i_tx_done` in 1: from `uart_txx` o_done.

## Operation
- **States:**
  - SYNC: entered on reset and after a WAIT_DONE timeout.
  - ARB, LAUNCH, WAIT_DONE.
- **SYNC → ARB:** when `i_tx_active`=0 and `i_tx_done`=0. This absorbs a transmitter frame still in flight across an arbiter reset.
- **ARB, unlocked:**
  - Pick the first k with `i_req_valid[k]`, scanning ptr, ptr+1, … mod NUM_REQ.
  - Load the owner into `o_grant` and go to LAUNCH.
  - With no valid requester, stay in ARB with `o_grant`=0.
- **ARB, locked:**
  - Serve only the owner. If its valid is high, go to LAUNCH.
  - Otherwise count idle cycles. At DONE_TIMEOUT-1: clear the lock, set ptr=owner+1, pulse `o_timeout`, clear `o_grant`, stay in ARB.
- **LAUNCH (one cycle):**
  - Drive `o_tx_data_avail`=1, `o_tx_databyte` = owner's data, and `o_req_ready[owner]`=1. The byte is accepted at this edge.
  - Set lock = ~`i_req_last[owner]`, clear the counter, go to WAIT_DONE.
- **WAIT_DONE:**
  - On `i_tx_done`: if the message is unlocked, set ptr=owner+1 mod N and clear `o_grant`. Go to ARB.
  - Otherwise increment the counter. At DONE_TIMEOUT-1: pulse `o_timeout`, clear the lock and `o_grant`, set ptr=owner+1, go to SYNC.
- **Simultaneous events:**
  - `i_tx_done` in the same cycle the counter reaches its limit: done wins, no timeout.
  - `i_tx_done` outside WAIT_DONE is ignored.
- **Width and range rules:**
  - The counter is 16-bit unsigned and saturates at no point: it is cleared on every state entry.
  - ptr is ceil(log2(NUM_REQ)) bits and wraps explicitly at NUM_REQ-1 → 0.

## Timing
- **Reset values:** state=SYNC, ptr=0, lock=0, counter=0. All outputs are 0, including `o_tx_databyte`=8'h00.
- **Minimum latency:** valid rising in cycle n (in ARB, unlocked) → LAUNCH in n+1 → `uart_txx` samples the strobe at the end of n+1.
- **Strobe width:** `o_tx_data_avail` is never high for more than one cycle. It is never high while `i_tx_active`=1 or in the `i_tx_done` cycle.
- **Back-to-back bytes:** `i_tx_done` in cycle d → ARB at d+1 → LAUNCH at d+2.
- **Handshake:** `o_req_ready` is asserted only in LAUNCH, only for the owner, and only with that owner's valid high.
- **Reset mid-operation:** any byte not yet accepted stays with its requester. A frame already in the transmitter completes, and SYNC waits it out.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding localparams (SYNC/ARB/LAUNCH/WAIT_DONE).
  - UART_DATA_W=8.
  - Default CLKS_PER_BIT=543.
  - DEFAULT_DONE_TIMEOUT=8192.
- **Sub-module `uart_rr_pick`:** combinational rotate/find-first-set/unrotate. Inputs are the request vector and ptr; outputs are a one-hot grant and any_req. It is reused by later schedulers.
- **Top:** the state machine, counter, lock/ptr registers, and data mux live in `uart_tx_arbiter`.

## Test plan
- **Single byte:** requester 2 sends 8'hA5 with last=1 → one `o_tx_data_avail` pulse, `o_req_ready`=4'b0100 for one cycle, `o_tx_databyte`=8'hA5. The serial line carries 0,1,0,1,0,0,1,0,1,1; `o_grant` returns to 0.
- **Fairness:** all four valid with last=1, ptr=0 → grant order 0,1,2,3,0. Each launch occurs exactly 2 cycles after the previous `i_tx_done`.
- **Lock:** requester 1 sends 3 bytes (last on the third) while requester 0 is valid → bytes 1a,1b,1c go out contiguously, then requester 0.
- **Abandoned lock:** requester 3 sends last=0 then drops valid → after DONE_TIMEOUT idle cycles, `o_timeout` pulses, and requester 0's pending byte launches next.
- **Stalled transmitter:** tie `i_tx_done`=0 → `o_timeout` at DONE_TIMEOUT cycles after LAUNCH, state SYNC, no further strobe until `i_tx_active`=0.
- **Reset mid-frame:** assert `rst` during bit 4 of a frame → the transmitter finishes the frame, and no new strobe appears before `i_tx_active` falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side schedulers.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int CLKS_PER_BIT         = 543;
  localparam int DEFAULT_DONE_TIMEOUT = 8192;

  localparam logic [1:0] S_SYNC      = 2'd0;
  localparam logic [1:0] S_ARB       = 2'd1;
  localparam logic [1:0] S_LAUNCH    = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC      = S_SYNC,
    ST_ARB       = S_ARB,
    ST_LAUNCH    = S_LAUNCH,
    ST_WAIT_DONE = S_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART TX arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [UART_DATA_W*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]             i_req_last;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [NUM_REQ-1:0]             o_grant;
  logic                           o_busy;
  logic                           o_timeout;
  logic                           o_tx_data_avail;
  logic [UART_DATA_W-1:0]         o_tx_databyte;
  logic                           i_tx_active;
  logic                           i_tx_done;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
    output o_req_ready, o_grant, o_busy, o_timeout, o_tx_data_avail, o_tx_databyte
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
    input  o_req_ready, o_grant, o_busy, o_timeout, o_tx_data_avail, o_tx_databyte
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin pick: rotate requests by ptr, take the first set bit, rotate back.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       any_req_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_rot;

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int ofs);
    int j;
    j = int'(base) + ofs;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return PTR_W'(j);
  endfunction

  always_comb begin
    req_rot = '0;
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) req_rot[i] = req_i[rot_idx(ptr_i, i)];
    gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    for (int i = 0; i < NUM_REQ; i++) grant_o[rot_idx(ptr_i, i)] = gnt_rot[i];
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_txx among NUM_REQ byte sources, with
// per-message grant lock and a watchdog on both the transmitter and the lock owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int          PTR_W     = $clog2(NUM_REQ);
  localparam logic [15:0] CNT_LIMIT = 16'(DONE_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               lock_q, lock_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               timeout_pulse;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) idx = PTR_W'(i);
    return idx;
  endfunction

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (bus.i_req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (pick_gnt),
    .any_req_o (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SYNC;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    lock_d        = lock_q;
    cnt_d         = cnt_q;
    timeout_pulse = 1'b0;
    case (state_q)
      // A frame left running across reset must drain before anything is launched.
      ST_SYNC: begin
        cnt_d = '0;
        if (!bus.i_tx_active && !bus.i_tx_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (lock_q) begin
          if (bus.i_req_valid[owner_q]) begin
            cnt_d   = '0;
            state_d = ST_LAUNCH;
          end else if (cnt_q == CNT_LIMIT) begin
            timeout_pulse = 1'b1;
            lock_d        = 1'b0;
            grant_d       = '0;
            ptr_d         = next_ptr(owner_q);
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = '0;
          if (pick_any) begin
            grant_d = pick_gnt;
            owner_d = onehot_idx(pick_gnt);
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        lock_d  = ~bus.i_req_last[owner_q];
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (bus.i_tx_done) begin
          if (!lock_q) begin
            ptr_d   = next_ptr(owner_q);
            grant_d = '0;
          end
          cnt_d   = '0;
          state_d = ST_ARB;
        end else if (cnt_q == CNT_LIMIT) begin
          timeout_pulse = 1'b1;
          lock_d        = 1'b0;
          grant_d       = '0;
          ptr_d         = next_ptr(owner_q);
          cnt_d         = '0;
          state_d       = ST_SYNC;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign bus.o_tx_data_avail = (state_q == ST_LAUNCH);
  assign bus.o_tx_databyte   = (state_q == ST_LAUNCH) ?
                               bus.i_req_data[owner_q*UART_DATA_W +: UART_DATA_W] : '0;
  assign bus.o_req_ready     = (state_q == ST_LAUNCH) ? (grant_q & bus.i_req_valid) : '0;
  assign bus.o_grant         = grant_q;
  assign bus.o_busy          = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE);
  assign bus.o_timeout       = timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_txx and byte-queue requesters.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TO    = 64;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .DONE_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [8:0]     rq [N][$];
  int             vrise [N];
  logic [N-1:0]   rdy_prev = '0;
  logic           avail_prev = 1'b0;
  int             cyc = 0;
  int             tx_left = 0;
  bit             stall = 1'b0;
  int             viol = 0;
  int             to_cnt = 0;
  int             lg_own[$];
  logic [7:0]     lg_dat[$];
  logic [N-1:0]   lg_rdy[$];
  int             lg_cyc[$];
  int             done_cyc[$];
  int             to_cyc[$];

  int         fair_own [5] = '{0, 1, 2, 3, 0};
  logic [7:0] fair_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  int         lock_own [4] = '{1, 1, 1, 0};
  logic [7:0] lock_dat [4] = '{8'h1A, 8'h1B, 8'h1C, 8'h0F};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push(input int k, input logic last, input logic [7:0] d);
    rq[k].push_back({last, d});
  endtask

  // One cycle: observe outputs, retire accepted bytes, advance the transmitter, drive requesters.
  task automatic tick();
    logic [N-1:0]   v, l;
    logic [8*N-1:0] d;
    logic [8:0]     h;
    @(negedge clk);
    cyc++;
    if (bus.o_tx_data_avail === 1'b1) begin
      if (bus.i_tx_active || bus.i_tx_done || avail_prev) viol++;
      if (bus.o_req_ready !== bus.o_grant || $countones(bus.o_grant) != 1) viol++;
      lg_own.push_back(idx_of(bus.o_grant));
      lg_dat.push_back(bus.o_tx_databyte);
      lg_rdy.push_back(bus.o_req_ready);
      lg_cyc.push_back(cyc);
    end else if (bus.o_req_ready !== '0) begin
      viol++;
    end
    if (bus.o_timeout === 1'b1) begin
      to_cnt++;
      to_cyc.push_back(cyc);
    end
    avail_prev = bus.o_tx_data_avail;
    for (int k = 0; k < N; k++) if (rdy_prev[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    rdy_prev = bus.o_req_ready;

    bus.i_tx_done = 1'b0;
    if (tx_left > 0 && !stall) begin
      tx_left--;
      if (tx_left == 0) begin
        bus.i_tx_active = 1'b0;
        bus.i_tx_done   = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
    if (tx_left == 0 && bus.i_tx_done !== 1'b1) bus.i_tx_active = 1'b0;
    if (bus.o_tx_data_avail === 1'b1) begin
      bus.i_tx_active = 1'b1;
      tx_left         = FRAME;
    end

    v = '0; l = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        h = rq[k][0];
        v[k] = 1'b1;
        l[k] = h[8];
        d[8*k +: 8] = h[7:0];
        if (bus.i_req_valid[k] !== 1'b1) vrise[k] = cyc;
      end
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = d;
  endtask

  task automatic wait_launch(input int n, input int budget);
    int i;
    i = 0;
    while (lg_own.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (lg_own.size() < n) check("wait_launch", lg_own.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && !(tx_left == 0 && bus.o_busy == 1'b0 && queues_empty())) begin
      tick();
      i++;
    end
    if (i >= budget) check("wait_idle", i, 0);
    tick();
    tick();
  endtask

  initial begin
    int base, dbase, tbase, i;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_grant",   bus.o_grant,         0);
    check("rst_ready",   bus.o_req_ready,     0);
    check("rst_busy",    bus.o_busy,          0);
    check("rst_timeout", bus.o_timeout,       0);
    check("rst_avail",   bus.o_tx_data_avail, 0);
    check("rst_byte",    bus.o_tx_databyte,   0);
    rst = 1'b0;
    repeat (3) tick();

    // Fairness from ptr=0
    base = lg_own.size(); dbase = done_cyc.size();
    push(0, 1'b1, 8'h10); push(1, 1'b1, 8'h11); push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13); push(0, 1'b1, 8'h14);
    wait_launch(base + 5, 400);
    wait_idle(200);
    for (int k = 0; k < 5; k++) begin
      check("fair_owner", lg_own[base + k], fair_own[k]);
      check("fair_byte",  lg_dat[base + k], fair_dat[k]);
    end
    for (int k = 1; k < 5; k++) check("fair_gap", lg_cyc[base + k] - done_cyc[dbase + k - 1], 2);

    // Single byte from requester 2
    base = lg_own.size();
    push(2, 1'b1, 8'hA5);
    wait_launch(base + 1, 50);
    check("single_owner",   lg_own[base], 2);
    check("single_byte",    lg_dat[base], 8'hA5);
    check("single_ready",   lg_rdy[base], 4'b0100);
    check("single_latency", lg_cyc[base] - vrise[2], 1);
    repeat (5) tick();
    check("single_busy",    bus.o_busy,  1);
    check("single_grant",   bus.o_grant, 4'b0100);
    wait_idle(100);
    check("single_grant_clr", bus.o_grant, 0);
    check("single_count",     lg_own.size() - base, 1);

    // Locked three-byte message with a competing requester
    base = lg_own.size();
    push(1, 1'b0, 8'h1A); push(1, 1'b0, 8'h1B); push(1, 1'b1, 8'h1C);
    wait_launch(base + 1, 50);
    push(0, 1'b1, 8'h0F);
    wait_launch(base + 4, 400);
    wait_idle(200);
    for (int k = 0; k < 4; k++) begin
      check("lock_owner", lg_own[base + k], lock_own[k]);
      check("lock_byte",  lg_dat[base + k], lock_dat[k]);
    end

    // Abandoned lock
    base = lg_own.size(); dbase = done_cyc.size(); tbase = to_cnt;
    push(3, 1'b0, 8'h3E);
    wait_launch(base + 1, 50);
    push(0, 1'b1, 8'h77);
    repeat (FRAME + 10) tick();
    check("abandon_grant_held", bus.o_grant, 4'b1000);
    check("abandon_held_off",   lg_own.size() - base, 1);
    wait_launch(base + 2, 2 * TO);
    check("abandon_to_count", to_cnt - tbase, 1);
    if (to_cnt > tbase) begin
      check("abandon_to_delay",   to_cyc[to_cyc.size() - 1] - done_cyc[dbase], TO);
      check("abandon_next_delay", lg_cyc[base + 1] - to_cyc[to_cyc.size() - 1], 2);
    end
    check("abandon_owner", lg_own[base + 1], 0);
    check("abandon_byte",  lg_dat[base + 1], 8'h77);
    wait_idle(200);

    // Stalled transmitter
    stall = 1'b1;
    base = lg_own.size(); tbase = to_cnt;
    push(2, 1'b1, 8'h3C);
    wait_launch(base + 1, 50);
    push(1, 1'b1, 8'h55);
    i = 0;
    while (to_cnt == tbase && i < 2 * TO) begin
      tick();
      i++;
    end
    check("stall_to_count", to_cnt - tbase, 1);
    if (to_cnt > tbase) check("stall_to_delay", to_cyc[to_cyc.size() - 1] - lg_cyc[base], TO);
    tick();
    check("stall_busy",  bus.o_busy,  0);
    check("stall_grant", bus.o_grant, 0);
    repeat (20) tick();
    check("stall_no_strobe", lg_own.size() - base, 1);
    dbase = done_cyc.size();
    stall = 1'b0;
    wait_launch(base + 2, FRAME + 20);
    check("stall_owner",  lg_own[base + 1], 1);
    check("stall_byte",   lg_dat[base + 1], 8'h55);
    check("stall_resume", lg_cyc[base + 1] - done_cyc[dbase], 3);
    wait_idle(200);

    // Reset during bit 4 of a frame
    base = lg_own.size(); dbase = done_cyc.size();
    push(0, 1'b1, 8'hC3);
    wait_launch(base + 1, 50);
    push(2, 1'b1, 8'h99);
    repeat (4 * CPB + 2) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy",  bus.o_busy,          0);
    check("midrst_grant", bus.o_grant,         0);
    check("midrst_avail", bus.o_tx_data_avail, 0);
    tick();
    rst = 1'b0;
    wait_launch(base + 2, FRAME + 20);
    check("midrst_owner",  lg_own[base + 1], 2);
    check("midrst_byte",   lg_dat[base + 1], 8'h99);
    check("midrst_resume", lg_cyc[base + 1] - done_cyc[dbase], 3);
    wait_idle(200);

    check("strobe_rules",   viol,   0);
    check("total_timeouts", to_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
